// File: rtl/pipe_ctrl.sv
// Pipeline sequencer for the 5-stage core: per-stage stall/flush control,
// hazard arbitration (mem wait, multi-cycle EX, branch, load-use) and stall counting.
module pipe_ctrl #(
  parameter int MC_LAT = 32,
  parameter int CNT_W  = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_mem_busy,
  input  logic        i_ex_mc_start,
  input  logic        i_ex_branch,
  input  logic [31:0] i_ex_target,
  input  logic        i_id_load_use,
  output logic [5:0]  o_stall,
  output logic        o_flush,
  output logic        o_pc_load,
  output logic [31:0] o_pc_target,
  output logic        o_mc_done,
  output logic [31:0] o_stall_cnt
);

  localparam logic S_RUN    = 1'b0;
  localparam logic S_MCWAIT = 1'b1;

  localparam logic [5:0] STALL_MEM  = 6'b011111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_LU   = 6'b000111;
  localparam logic [5:0] STALL_NONE = 6'b000000;

  // The start cycle already counts as one stall cycle, so MCWAIT loads MC_LAT-1.
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MC_LAT - 1);

  logic             state;
  logic             state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [31:0]      stall_cnt;

  always_comb begin
    o_stall     = STALL_NONE;
    o_flush     = 1'b0;
    o_pc_load   = 1'b0;
    o_pc_target = 32'h0;
    o_mc_done   = 1'b0;
    state_nxt   = state;
    cnt_nxt     = cnt;

    if (rst) begin
      state_nxt = S_RUN;
      cnt_nxt   = '0;
    end else begin
      case (state)
        S_RUN: begin
          if (i_mem_busy) begin
            o_stall = STALL_MEM;
          end else if (i_ex_mc_start) begin
            o_stall   = STALL_EX;
            state_nxt = S_MCWAIT;
            cnt_nxt   = CNT_INIT;
          end else if (i_ex_branch) begin
            o_flush     = 1'b1;
            o_pc_load   = 1'b1;
            o_pc_target = i_ex_target;
          end else if (i_id_load_use) begin
            o_stall = STALL_LU;
          end
        end
        S_MCWAIT: begin
          // The mul/div unit keeps counting even while MEM is held.
          if (cnt != '0) begin
            o_stall = i_mem_busy ? STALL_MEM : STALL_EX;
            cnt_nxt = cnt - CNT_W'(1);
          end else if (i_mem_busy) begin
            o_stall = STALL_MEM;
          end else begin
            o_mc_done = 1'b1;
            state_nxt = S_RUN;
          end
        end
        default: begin
          state_nxt = S_RUN;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_RUN;
      cnt       <= '0;
      stall_cnt <= 32'h0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (|o_stall) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
    end
  end

  assign o_stall_cnt = stall_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus randomized traffic
// checked against a cycle-count reference model of the hazard rules.
module tb_pipe_ctrl;

  localparam int MC_LAT = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        mem_busy = 1'b0;
  logic        mc_start = 1'b0;
  logic        branch = 1'b0;
  logic        load_use = 1'b0;
  logic [31:0] target = 32'h0;
  logic [5:0]  stall;
  logic        flush, pc_load, mc_done;
  logic [31:0] pc_target, stall_cnt;

  logic        rst_l = 1'b1;
  logic        mc_l = 1'b0;
  logic [5:0]  stall_l;
  logic        flush_l, pc_load_l, mc_done_l;
  logic [31:0] pc_target_l, stall_cnt_l;

  int checks = 0;
  int failures = 0;

  // Reference model: whether a mul/div op is in flight and how many cycles it has used.
  logic        m_in_mc = 1'b0;
  int          m_cycles = 0;
  logic [31:0] m_scnt = 32'h0;
  logic [5:0]  e_stall;
  logic        e_flush, e_load, e_done, e_start;
  logic [31:0] e_tgt;

  pipe_ctrl #(.MC_LAT(MC_LAT), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .i_mem_busy(mem_busy), .i_ex_mc_start(mc_start),
    .i_ex_branch(branch), .i_ex_target(target), .i_id_load_use(load_use),
    .o_stall(stall), .o_flush(flush), .o_pc_load(pc_load), .o_pc_target(pc_target),
    .o_mc_done(mc_done), .o_stall_cnt(stall_cnt)
  );

  pipe_ctrl #(.MC_LAT(32), .CNT_W(6)) dut_long (
    .clk(clk), .rst(rst_l), .i_mem_busy(1'b0), .i_ex_mc_start(mc_l),
    .i_ex_branch(1'b0), .i_ex_target(32'h0), .i_id_load_use(1'b0),
    .o_stall(stall_l), .o_flush(flush_l), .o_pc_load(pc_load_l), .o_pc_target(pc_target_l),
    .o_mc_done(mc_done_l), .o_stall_cnt(stall_cnt_l)
  );

  task automatic expectEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic modelEval();
    e_stall = 6'b000000;
    e_flush = 1'b0;
    e_load  = 1'b0;
    e_tgt   = 32'h0;
    e_done  = 1'b0;
    e_start = 1'b0;
    if (rst) begin
      e_stall = 6'b000000;
    end else if (m_in_mc) begin
      if (m_cycles < MC_LAT) e_stall = mem_busy ? 6'b011111 : 6'b001111;
      else if (mem_busy) e_stall = 6'b011111;
      else e_done = 1'b1;
    end else if (mem_busy) begin
      e_stall = 6'b011111;
    end else if (mc_start) begin
      e_stall = 6'b001111;
      e_start = 1'b1;
    end else if (branch) begin
      e_flush = 1'b1;
      e_load  = 1'b1;
      e_tgt   = target;
    end else if (load_use) begin
      e_stall = 6'b000111;
    end
  endtask

  task automatic modelUpdate();
    if (rst) begin
      m_in_mc  = 1'b0;
      m_cycles = 0;
      m_scnt   = 32'h0;
    end else begin
      if (e_stall != 6'b000000) m_scnt = m_scnt + 32'd1;
      if (m_in_mc) begin
        if (e_done) m_in_mc = 1'b0;
        else m_cycles = m_cycles + 1;
      end else if (e_start) begin
        m_in_mc  = 1'b1;
        m_cycles = 1;
      end
    end
  endtask

  task automatic applyStimulus(input logic r, input logic b, input logic m, input logic br,
                               input logic [31:0] t, input logic lu);
    @(negedge clk);
    rst = r; mem_busy = b; mc_start = m; branch = br; target = t; load_use = lu;
    #1;
    modelEval();
  endtask

  task automatic checkOutput(input string tag);
    expectEq({tag, ".stall"}, {26'h0, stall}, {26'h0, e_stall});
    expectEq({tag, ".flush"}, {31'h0, flush}, {31'h0, e_flush});
    expectEq({tag, ".pc_load"}, {31'h0, pc_load}, {31'h0, e_load});
    expectEq({tag, ".pc_target"}, pc_target, e_tgt);
    expectEq({tag, ".mc_done"}, {31'h0, mc_done}, {31'h0, e_done});
    expectEq({tag, ".stall_cnt"}, stall_cnt, m_scnt);
  endtask

  task automatic tick();
    @(posedge clk);
    modelUpdate();
  endtask

  task automatic longStep(input logic r, input logic m);
    @(negedge clk);
    rst_l = r; mc_l = m;
    #1;
  endtask

  initial begin
    $display("[TB] start");

    // Reset in the middle of a long multi-cycle op (MC_LAT=32, cnt=5).
    longStep(1'b1, 1'b0);
    longStep(1'b0, 1'b1);
    expectEq("long.start_stall", {26'h0, stall_l}, 32'h0F);
    for (int k = 1; k <= 27; k++) longStep(1'b0, 1'b0);
    expectEq("long.cnt5_stall", {26'h0, stall_l}, 32'h0F);
    expectEq("long.cnt5_stall_cnt", stall_cnt_l, 32'd27);
    for (int k = 0; k < 2; k++) begin
      longStep(1'b1, 1'b0);
      expectEq("long.rst_stall", {26'h0, stall_l}, 32'h0);
      expectEq("long.rst_flush", {31'h0, flush_l}, 32'h0);
      expectEq("long.rst_pc_load", {31'h0, pc_load_l}, 32'h0);
      expectEq("long.rst_pc_target", pc_target_l, 32'h0);
      expectEq("long.rst_mc_done", {31'h0, mc_done_l}, 32'h0);
    end
    expectEq("long.rst_stall_cnt", stall_cnt_l, 32'h0);
    for (int k = 0; k < 40; k++) begin
      longStep(1'b0, 1'b0);
      expectEq("long.post_mc_done", {31'h0, mc_done_l}, 32'h0);
      expectEq("long.post_stall", {26'h0, stall_l}, 32'h0);
    end
    expectEq("long.post_stall_cnt", stall_cnt_l, 32'h0);

    // Main instance: reset state.
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 32'h1234, 1'b1); checkOutput("rst0"); tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0); checkOutput("rst1"); tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0); checkOutput("idle");
    expectEq("idle.stall_cnt", stall_cnt, 32'h0);
    tick();

    // Multi-cycle op with no memory wait.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0); checkOutput("mc.c0");
    expectEq("mc.c0_stall", {26'h0, stall}, 32'h0F);
    tick();
    for (int c = 1; c <= 3; c++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h99, 1'b1); checkOutput("mc.wait");
      expectEq("mc.wait_stall", {26'h0, stall}, 32'h0F);
      tick();
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0); checkOutput("mc.c4");
    expectEq("mc.c4_done", {31'h0, mc_done}, 32'h1);
    expectEq("mc.c4_stall", {26'h0, stall}, 32'h0);
    expectEq("mc.c4_stall_cnt", stall_cnt, 32'd4);
    tick();

    // Branch beats load-use.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0040, 1'b1); checkOutput("br");
    expectEq("br.flush", {31'h0, flush}, 32'h1);
    expectEq("br.pc_target", pc_target, 32'h40);
    tick();

    // Single load-use bubble.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1); checkOutput("lu");
    expectEq("lu.stall", {26'h0, stall}, 32'h07);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0); checkOutput("lu.after");
    tick();

    // Memory wait masks a pending branch until it clears.
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0100, 1'b0); checkOutput("busybr");
      expectEq("busybr.pc_load", {31'h0, pc_load}, 32'h0);
      tick();
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0100, 1'b0); checkOutput("busybr.rel");
    expectEq("busybr.rel_pc_load", {31'h0, pc_load}, 32'h1);
    tick();

    // Multi-cycle op overlapped by a memory wait in cycles 2-6.
    for (int c = 0; c <= 7; c++) begin
      applyStimulus(1'b0, (c >= 2 && c <= 6), (c == 0), 1'b0, 32'h0, 1'b0);
      checkOutput("mcbusy");
      if (c >= 2 && c <= 6) expectEq("mcbusy.stall", {26'h0, stall}, 32'h1F);
      expectEq("mcbusy.done", {31'h0, mc_done}, {31'h0, (c == 7)});
      tick();
    end

    // Stall counter wraps from all-ones to zero.
    @(negedge clk);
    force dut.stall_cnt = 32'hFFFF_FFFF;
    m_scnt = 32'hFFFF_FFFF;
    rst = 1'b0; mem_busy = 1'b0; mc_start = 1'b0; branch = 1'b0; load_use = 1'b1;
    #1;
    modelEval();
    checkOutput("wrap.pre");
    #2;
    release dut.stall_cnt;
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0); checkOutput("wrap.post");
    expectEq("wrap.stall_cnt", stall_cnt, 32'h0);
    tick();

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 400; c++) begin
      applyStimulus(($urandom_range(49) == 0), ($urandom_range(3) == 0), ($urandom_range(5) == 0),
                    ($urandom_range(3) == 0), $urandom, ($urandom_range(2) == 0));
      checkOutput("rand");
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
